uart_tx_buf: RTL and testbench



---
 rtl/uart_tx_buf_pkg.sv | 17 +
 rtl/uart_sync_fifo.sv | 103 ++++++++++
 rtl/uart_tx_buf.sv | 127 ++++++++++++
 tb/tb_uart_tx_buf.sv | 270 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_tx_buf_pkg.sv
// Shared definitions for the UART transmit buffer: byte width and launch FSM state encodings.
// Latency: none (types and constants only).
// Backpressure: not applicable.
package uart_tx_buf_pkg;

    // Native UART character width used as the default byte width.
    localparam int UART_DATA_WIDTH = 8;

    // Launch sequencer states (2-bit encoding).
    typedef enum logic [1:0] {
        TXB_IDLE   = 2'd0,
        TXB_LAUNCH = 2'd1,
        TXB_ARM    = 2'd2,
        TXB_DRAIN  = 2'd3
    } txb_state_e;

endpackage

// File: rtl/uart_sync_fifo.sv
// Single-clock circular FIFO with registered occupancy, full/empty decode and sticky overflow.
// Latency: a push is visible at the head one cycle after acceptance; the head is read combinationally.
// Backpressure: pushes are dropped while full (and raise ovf_o); pops while empty are ignored.
//
// Ports:
//   clk_i, rst_n_i      clock, async active-low reset
//   push_i/push_dat_i   write strobe and data
//   pop_i/pop_dat_o     advance read pointer / current head entry
//   full_o, empty_o     decoded from the registered count
//   count_o             occupancy, one bit wider than the pointers
//   ovf_o, ovf_clr_i    sticky overflow flag and its clear
module uart_sync_fifo
    import uart_tx_buf_pkg::*;
#(
    parameter int DATA_WIDTH = UART_DATA_WIDTH,
    parameter int DEPTH_LOG2 = 4
) (
    input  logic                  clk_i,
    input  logic                  rst_n_i,
    input  logic                  push_i,
    input  logic [DATA_WIDTH-1:0] push_dat_i,
    input  logic                  pop_i,
    output logic [DATA_WIDTH-1:0] pop_dat_o,
    output logic                  full_o,
    output logic                  empty_o,
    output logic [DEPTH_LOG2:0]   count_o,
    output logic                  ovf_o,
    input  logic                  ovf_clr_i
);

    localparam int                DEPTH    = 1 << DEPTH_LOG2;
    localparam logic [DEPTH_LOG2:0] FULL_CNT = (DEPTH_LOG2 + 1)'(DEPTH);

    logic [DATA_WIDTH-1:0]   mem_q [DEPTH];
    logic [DEPTH_LOG2-1:0]   wr_ptr_q, wr_ptr_d;
    logic [DEPTH_LOG2-1:0]   rd_ptr_q, rd_ptr_d;
    logic [DEPTH_LOG2:0]     count_q, count_d;
    logic                    ovf_q, ovf_d;
    logic                    wr_en;
    logic                    rd_en;
    logic                    wr_drop;

    assign full_o    = (count_q == FULL_CNT);
    assign empty_o   = (count_q == '0);
    assign count_o   = count_q;
    assign ovf_o     = ovf_q;
    assign pop_dat_o = mem_q[rd_ptr_q];

    // Write acceptance depends only on the registered full flag, so a pop in
    // the same cycle does not make room for a write arriving while full.
    assign wr_en   = push_i & ~full_o;
    assign wr_drop = push_i &  full_o;
    assign rd_en   = pop_i  & ~empty_o;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        ovf_d    = ovf_q;

        if (wr_en) begin
            wr_ptr_d = wr_ptr_q + DEPTH_LOG2'(1);
        end
        if (rd_en) begin
            rd_ptr_d = rd_ptr_q + DEPTH_LOG2'(1);
        end

        case ({wr_en, rd_en})
            2'b10:   count_d = count_q + (DEPTH_LOG2 + 1)'(1);
            2'b01:   count_d = count_q - (DEPTH_LOG2 + 1)'(1);
            default: count_d = count_q;
        endcase

        // A fresh overflow beats a clear arriving in the same cycle.
        if (wr_drop) begin
            ovf_d = 1'b1;
        end else if (ovf_clr_i) begin
            ovf_d = 1'b0;
        end
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            ovf_q    <= 1'b0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            ovf_q    <= ovf_d;
        end
    end

    // Storage is not reset; the pointers and count define which entries are live.
    always_ff @(posedge clk_i) begin
        if (wr_en) begin
            mem_q[wr_ptr_q] <= push_dat_i;
        end
    end

endmodule

// File: rtl/uart_tx_buf.sv
// Byte buffer and launch sequencer feeding uart_tx one byte per busy handshake.
// Latency: byte accepted into an empty buffer at edge N launches (tx_o_v high) during N+1..N+2.
// Backpressure: bytes arriving while full are dropped and flagged on ovf_o; no launch while tx_busy_i=1.
//
// Ports:
//   clk_i, rst_n_i        clock, async active-low reset
//   rx_i, rx_i_v          byte in and write strobe
//   full_o, empty_o       buffer status
//   count_o               occupancy (DEPTH_LOG2+1 bits)
//   ovf_o, ovf_clr_i      sticky overflow flag and clear
//   tx_o, tx_o_v          byte and one-cycle launch pulse to uart_tx
//   tx_busy_i             uart_tx busy indication
module uart_tx_buf
    import uart_tx_buf_pkg::*;
#(
    parameter int DATA_WIDTH = UART_DATA_WIDTH,
    parameter int DEPTH_LOG2 = 4,
    parameter int BUSY_TO    = 4
) (
    input  logic                  clk_i,
    input  logic                  rst_n_i,
    input  logic [DATA_WIDTH-1:0] rx_i,
    input  logic                  rx_i_v,
    output logic                  full_o,
    output logic                  empty_o,
    output logic [DEPTH_LOG2:0]   count_o,
    output logic                  ovf_o,
    input  logic                  ovf_clr_i,
    output logic [DATA_WIDTH-1:0] tx_o,
    output logic                  tx_o_v,
    input  logic                  tx_busy_i
);

    localparam int            TW       = (BUSY_TO < 1) ? 1 : $clog2(BUSY_TO + 1);
    localparam logic [TW-1:0] TO_LIMIT = TW'(BUSY_TO);

    txb_state_e              state_q, state_d;
    logic [DATA_WIDTH-1:0]   tx_q, tx_d;
    logic                    tx_v_q, tx_v_d;
    logic [TW-1:0]           to_cnt_q, to_cnt_d;
    logic                    pop;
    logic [DATA_WIDTH-1:0]   head_dat;
    logic                    fifo_empty;

    uart_sync_fifo #(
        .DATA_WIDTH (DATA_WIDTH),
        .DEPTH_LOG2 (DEPTH_LOG2)
    ) u_fifo (
        .clk_i      (clk_i),
        .rst_n_i    (rst_n_i),
        .push_i     (rx_i_v),
        .push_dat_i (rx_i),
        .pop_i      (pop),
        .pop_dat_o  (head_dat),
        .full_o     (full_o),
        .empty_o    (fifo_empty),
        .count_o    (count_o),
        .ovf_o      (ovf_o),
        .ovf_clr_i  (ovf_clr_i)
    );

    assign empty_o = fifo_empty;
    assign tx_o    = tx_q;
    assign tx_o_v  = tx_v_q;

    always_comb begin
        state_d  = state_q;
        tx_d     = tx_q;
        to_cnt_d = to_cnt_q;
        pop      = 1'b0;

        case (state_q)
            TXB_IDLE: begin
                // uart_tx may still be busy here (e.g. it rose after a timeout);
                // hold off until it is free so we never launch over it.
                if (!fifo_empty && !tx_busy_i) begin
                    tx_d    = head_dat;
                    pop     = 1'b1;
                    state_d = TXB_LAUNCH;
                end
            end
            TXB_LAUNCH: begin
                to_cnt_d = '0;
                state_d  = TXB_ARM;
            end
            TXB_ARM: begin
                if (tx_busy_i) begin
                    state_d = TXB_DRAIN;
                end else begin
                    // No busy response within BUSY_TO cycles: assume the byte went
                    // out and move on rather than stall the queue.
                    to_cnt_d = to_cnt_q + TW'(1);
                    if ((to_cnt_q + TW'(1)) == TO_LIMIT) begin
                        state_d = TXB_IDLE;
                    end
                end
            end
            TXB_DRAIN: begin
                if (!tx_busy_i) begin
                    state_d = TXB_IDLE;
                end
            end
            default: begin
                state_d = TXB_IDLE;
            end
        endcase

        // Launch strobe is registered from the next state so it is a clean
        // flop output that is high exactly while the FSM sits in LAUNCH.
        tx_v_d = (state_d == TXB_LAUNCH);
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state_q  <= TXB_IDLE;
            tx_q     <= '0;
            tx_v_q   <= 1'b0;
            to_cnt_q <= '0;
        end else begin
            state_q  <= state_d;
            tx_q     <= tx_d;
            tx_v_q   <= tx_v_d;
            to_cnt_q <= to_cnt_d;
        end
    end

endmodule

// File: tb/tb_uart_tx_buf.sv
// Self-checking bench for uart_tx_buf: directed writes feed an expected-byte queue,
// a monitor pops and compares on every launch pulse, and a uart_tx busy model responds.
// Latency/backpressure checks are made inline against hand-computed values.
module tb_uart_tx_buf;

    logic       clk_i = 1'b0;
    logic       rst_n_i;
    logic [7:0] rx_i;
    logic       rx_i_v;
    logic       full_o;
    logic       empty_o;
    logic [4:0] count_o;
    logic       ovf_o;
    logic       ovf_clr_i;
    logic [7:0] tx_o;
    logic       tx_o_v;
    logic       tx_busy_i;

    int         total = 0;
    int         bad = 0;
    int         cyc = 0;
    int         launch_cnt = 0;
    int         last_launch = 0;
    int         prev_launch = 0;
    logic [7:0] exp_q[$];

    bit         busy_force = 1'b0;
    bit         busy_auto = 1'b1;
    int         busy_len = 10;
    int         busy_cnt = 0;
    bit         busy_pend = 1'b0;

    uart_tx_buf dut (
        .clk_i     (clk_i),
        .rst_n_i   (rst_n_i),
        .rx_i      (rx_i),
        .rx_i_v    (rx_i_v),
        .full_o    (full_o),
        .empty_o   (empty_o),
        .count_o   (count_o),
        .ovf_o     (ovf_o),
        .ovf_clr_i (ovf_clr_i),
        .tx_o      (tx_o),
        .tx_o_v    (tx_o_v),
        .tx_busy_i (tx_busy_i)
    );

    initial forever #5 clk_i = ~clk_i;

    initial forever begin
        @(posedge clk_i);
        cyc++;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h want 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge clk_i);
    endtask

    task automatic wait_launch(input int target, input int budget);
        int n = 0;
        while (launch_cnt < target && n < budget) begin
            @(negedge clk_i);
            n++;
        end
        check("launch reached", (launch_cnt >= target) ? 1 : 0, 1);
    endtask

    // uart_tx busy model: busy rises one cycle after a launch and holds busy_len cycles.
    initial begin
        tx_busy_i = 1'b0;
        forever begin
            @(posedge clk_i);
            #2;
            if (!busy_auto) begin
                busy_cnt  = 0;
                busy_pend = 1'b0;
            end else begin
                if (busy_cnt > 0) busy_cnt--;
                if (busy_pend) begin
                    busy_cnt  = busy_len;
                    busy_pend = 1'b0;
                end
                if (tx_o_v) busy_pend = 1'b1;
            end
            tx_busy_i = busy_force || (busy_cnt > 0);
        end
    end

    // Monitor: every launch pulse must carry the next expected byte.
    initial forever begin
        @(negedge clk_i);
        if (tx_o_v === 1'b1) begin
            launch_cnt++;
            prev_launch = last_launch;
            last_launch = cyc;
            check("no launch while busy", {31'd0, tx_busy_i}, 0);
            if (exp_q.size() == 0) begin
                total++;
                bad++;
                $display("FAIL unexpected launch: got 0x%0h want none", tx_o);
            end else begin
                check("tx_o order", {24'd0, tx_o}, {24'd0, exp_q.pop_front()});
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int base;
        int wr_cyc;
        rst_n_i   = 1'b0;
        rx_i      = 8'h00;
        rx_i_v    = 1'b0;
        ovf_clr_i = 1'b0;
        tick(3);
        check("rst count", {27'd0, count_o}, 0);
        check("rst empty", {31'd0, empty_o}, 1);
        check("rst full",  {31'd0, full_o}, 0);
        check("rst ovf",   {31'd0, ovf_o}, 0);
        check("rst tx_o",  {24'd0, tx_o}, 0);
        check("rst tx_v",  {31'd0, tx_o_v}, 0);
        rst_n_i = 1'b1;
        tick(2);

        // Single byte: launch 2 cycles after write, one pulse only.
        base   = launch_cnt;
        wr_cyc = cyc;
        rx_i   = 8'hA5;
        rx_i_v = 1'b1;
        exp_q.push_back(8'hA5);
        tick(1);
        rx_i_v = 1'b0;
        check("single count1", {27'd0, count_o}, 1);
        tick(1);
        check("single empty after pop", {31'd0, empty_o}, 1);
        check("single launch seen", launch_cnt - base, 1);
        check("single latency", last_launch - wr_cyc, 2);
        tick(25);
        check("single one launch", launch_cnt - base, 1);
        check("single tx_o held", {24'd0, tx_o}, 32'hA5);

        // Burst with busy held: fill to full, then overflow handling.
        busy_force = 1'b1;
        tick(2);
        for (int i = 1; i <= 16; i++) begin
            rx_i   = 8'(i);
            rx_i_v = 1'b1;
            exp_q.push_back(8'(i));
            tick(1);
        end
        rx_i_v = 1'b0;
        check("burst full", {31'd0, full_o}, 1);
        check("burst count16", {27'd0, count_o}, 16);
        check("burst no launch", launch_cnt - base, 1);
        rx_i   = 8'hFF;
        rx_i_v = 1'b1;
        tick(1);
        rx_i_v = 1'b0;
        check("ovf count16", {27'd0, count_o}, 16);
        check("ovf set", {31'd0, ovf_o}, 1);
        ovf_clr_i = 1'b1;
        tick(1);
        ovf_clr_i = 1'b0;
        check("ovf cleared", {31'd0, ovf_o}, 0);
        rx_i      = 8'hFF;
        rx_i_v    = 1'b1;
        ovf_clr_i = 1'b1;
        tick(1);
        rx_i_v    = 1'b0;
        ovf_clr_i = 1'b0;
        check("ovf wins over clr", {31'd0, ovf_o}, 1);
        ovf_clr_i = 1'b1;
        tick(1);
        ovf_clr_i = 1'b0;
        check("ovf clr again", {31'd0, ovf_o}, 0);
        base       = launch_cnt;
        busy_force = 1'b0;
        wait_launch(base + 16, 1000);
        tick(25);
        check("burst drained", {31'd0, empty_o}, 1);

        // Simultaneous push/pop: count stays 3, 0x55 emerges fourth.
        busy_force = 1'b1;
        tick(2);
        for (int i = 0; i < 3; i++) begin
            rx_i   = 8'h31 + 8'(i);
            rx_i_v = 1'b1;
            exp_q.push_back(8'h31 + 8'(i));
            tick(1);
        end
        rx_i_v = 1'b0;
        check("pp count3 before", {27'd0, count_o}, 3);
        base       = launch_cnt;
        busy_force = 1'b0;
        tick(1);
        rx_i   = 8'h55;
        rx_i_v = 1'b1;
        exp_q.push_back(8'h55);
        tick(1);
        rx_i_v = 1'b0;
        check("pp count3 after", {27'd0, count_o}, 3);
        wait_launch(base + 4, 500);
        tick(25);

        // Busy timeout: no busy response, launches 6 cycles apart.
        busy_auto = 1'b0;
        tick(2);
        base = launch_cnt;
        for (int i = 0; i < 2; i++) begin
            rx_i   = 8'h61 + 8'(i);
            rx_i_v = 1'b1;
            exp_q.push_back(8'h61 + 8'(i));
            tick(1);
        end
        rx_i_v = 1'b0;
        wait_launch(base + 2, 100);
        check("timeout spacing", last_launch - prev_launch, 6);
        tick(15);
        check("timeout two launches", launch_cnt - base, 2);

        // Async reset mid-DRAIN with 5 bytes queued.
        busy_auto = 1'b1;
        busy_len  = 60;
        tick(2);
        base = launch_cnt;
        for (int i = 0; i < 6; i++) begin
            rx_i   = 8'h71 + 8'(i);
            rx_i_v = 1'b1;
            if (i == 0) exp_q.push_back(8'h71);
            tick(1);
        end
        rx_i_v = 1'b0;
        wait_launch(base + 1, 50);
        tick(5);
        check("drain count5", {27'd0, count_o}, 5);
        #2;
        rst_n_i = 1'b0;
        #1;
        check("arst count", {27'd0, count_o}, 0);
        check("arst empty", {31'd0, empty_o}, 1);
        check("arst full",  {31'd0, full_o}, 0);
        check("arst ovf",   {31'd0, ovf_o}, 0);
        check("arst tx_o",  {24'd0, tx_o}, 0);
        check("arst tx_v",  {31'd0, tx_o_v}, 0);
        busy_auto = 1'b0;
        tick(3);
        rst_n_i = 1'b1;
        tick(30);
        check("post reset no launch", launch_cnt - base, 1);
        check("post reset count", {27'd0, count_o}, 0);
        check("scoreboard empty", exp_q.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
